// File: rtl/count_pkg.sv
// Shared types and default timing for the push-button enable generator.
// Defaults give an 18-cycle press latency and a 64/16-cycle auto-repeat.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD_DELAY,
    HELD_REPEAT
  } eg_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 64;
  localparam int DEF_REPEAT_PERIOD   = 16;
  localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/sync_debounce.sv
// Synchronizer plus debounce filter for a raw push-button.
// 'pressed' is the registered debounced level; 'rise' flags the edge on which it will go 0->1.
module sync_debounce
  import count_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic pressed,
  output logic rise
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       db_cnt;
  logic                   btn_s;
  logic                   db_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button};
    end
  end

  assign btn_s   = sync_q[SYNC_STAGES-1];
  assign db_done = (btn_s != pressed) && (db_cnt == DB_LAST);

  // Rise is combinational so the FSM can fire its pulse on the same edge pressed rises.
  assign rise = db_done && btn_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pressed <= 1'b0;
      db_cnt  <= '0;
    end else if (btn_s != pressed) begin
      if (db_done) begin
        pressed <= btn_s;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

endmodule

// File: rtl/count_enable_gen.sv
// Turns a bouncy push-button into single-cycle enable pulses for the 4-bit counter,
// one per debounced press plus optional auto-repeat while held.
module count_enable_gen
  import count_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  input  logic repeat_en,
  output logic enable,
  output logic pressed
);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  eg_state_t        state, state_nxt;
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic             enable_nxt;
  logic             rise;

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sync_debounce (
    .clock   (clock),
    .reset   (reset),
    .button  (button),
    .pressed (pressed),
    .rise    (rise)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rpt_cnt <= '0;
      enable  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
      enable  <= enable_nxt;
    end
  end

  // A release that coincides with a new rise (only possible with very short debounce)
  // is taken as a fresh press rather than dropped.
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    enable_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          enable_nxt  = 1'b1;
          rpt_cnt_nxt = '0;
          state_nxt   = HELD_DELAY;
        end
      end
      HELD_DELAY: begin
        if (!pressed) begin
          rpt_cnt_nxt = '0;
          if (rise) begin
            enable_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (!repeat_en) begin
          rpt_cnt_nxt = '0;
        end else if (rpt_cnt == DELAY_LAST) begin
          enable_nxt  = 1'b1;
          rpt_cnt_nxt = '0;
          state_nxt   = HELD_REPEAT;
        end else begin
          rpt_cnt_nxt = rpt_cnt + 1'b1;
        end
      end
      HELD_REPEAT: begin
        if (!pressed) begin
          rpt_cnt_nxt = '0;
          if (rise) begin
            enable_nxt = 1'b1;
            state_nxt  = HELD_DELAY;
          end else begin
            state_nxt = IDLE;
          end
        end else if (!repeat_en) begin
          rpt_cnt_nxt = '0;
          state_nxt   = HELD_DELAY;
        end else if (rpt_cnt == PERIOD_LAST) begin
          enable_nxt  = 1'b1;
          rpt_cnt_nxt = '0;
        end else begin
          rpt_cnt_nxt = rpt_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        rpt_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_count_enable_gen.sv
// Scoreboard bench for count_enable_gen: directed press/bounce/repeat/reset scenarios
// followed by random button and repeat_en activity against a cycle-level reference model.
module tb_count_enable_gen;
  import count_pkg::*;

  localparam int SYNC = DEF_SYNC_STAGES;
  localparam int DEB  = DEF_DEBOUNCE_CYCLES;
  localparam int DLY  = DEF_REPEAT_DELAY;
  localparam int PER  = DEF_REPEAT_PERIOD;

  typedef struct packed {
    logic en;
    logic pr;
  } exp_t;

  logic clock     = 1'b0;
  logic reset     = 1'b1;
  logic button    = 1'b0;
  logic repeat_en = 1'b0;
  logic enable;
  logic pressed;

  exp_t exp_q[$];
  int   pulse_edges[$];
  int   want[$];
  int   n_vectors     = 0;
  int   n_miscompares = 0;
  int   edge_cnt      = 0;
  int   fall_edge     = 0;
  logic prev_pressed  = 1'b0;

  bit   hist[$];
  bit   m_pressed;
  int   m_run;
  bit   m_held;
  bit   m_in_repeat;
  int   m_hold;

  always #5 clock = ~clock;

  count_enable_gen #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (DLY),
    .REPEAT_PERIOD   (PER),
    .CNT_W           (DEF_CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .button    (button),
    .repeat_en (repeat_en),
    .enable    (enable),
    .pressed   (pressed)
  );

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    m_pressed   = 1'b0;
    m_run       = 0;
    m_held      = 1'b0;
    m_in_repeat = 1'b0;
    m_hold      = 0;
  endfunction

  // One clock edge of behaviour: delayed sample, stable-run debounce, then elapsed-hold timing.
  function automatic void model_step(input bit b, input bit ren, output exp_t e);
    bit btn_s, old_pressed, press_event, pulse;
    btn_s = hist.pop_front();
    hist.push_back(b);
    old_pressed = m_pressed;
    press_event = 1'b0;
    pulse       = 1'b0;
    if (btn_s != m_pressed) begin
      m_run++;
      if (m_run == DEB) begin
        m_pressed   = btn_s;
        m_run       = 0;
        press_event = btn_s;
      end
    end else begin
      m_run = 0;
    end
    if (m_held) begin
      if (!old_pressed) begin
        m_held = 1'b0;
      end else if (!ren) begin
        m_hold      = 0;
        m_in_repeat = 1'b0;
      end else begin
        m_hold++;
        if (m_hold == (m_in_repeat ? PER : DLY)) begin
          pulse       = 1'b1;
          m_hold      = 0;
          m_in_repeat = 1'b1;
        end
      end
    end
    if (press_event && !m_held) begin
      pulse       = 1'b1;
      m_held      = 1'b1;
      m_hold      = 0;
      m_in_repeat = 1'b0;
    end
    e.en = pulse;
    e.pr = m_pressed;
  endfunction

  task automatic apply_stimulus(input bit b, input bit ren, input bit rst_v);
    exp_t e;
    bit   was_running;
    @(negedge clock);
    was_running = reset;
    button      = b;
    repeat_en   = ren;
    reset       = rst_v;
    if (!rst_v) begin
      model_reset();
      e.en = 1'b0;
      e.pr = 1'b0;
      if (was_running) begin
        #1;
        check_output("reset_enable", {31'd0, enable}, 32'd0);
        check_output("reset_pressed", {31'd0, pressed}, 32'd0);
      end
    end else begin
      model_step(b, ren, e);
    end
    exp_q.push_back(e);
  endtask

  task automatic begin_scenario();
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
    pulse_edges = {};
    fall_edge   = 0;
  endtask

  task automatic check_pulses(input string name, input int limit);
    int got[$];
    @(posedge clock);
    #2;
    foreach (pulse_edges[i]) if (pulse_edges[i] <= limit) got.push_back(pulse_edges[i]);
    check_output({name, "_pulse_count"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      check_output({name, "_pulse_edge"}, got[i], want[i]);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset) edge_cnt++;
      else edge_cnt = 0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("enable", {31'd0, enable}, {31'd0, e.en});
        check_output("pressed", {31'd0, pressed}, {31'd0, e.pr});
      end
      if (reset && enable) pulse_edges.push_back(edge_cnt);
      if (reset && prev_pressed && !pressed) fall_edge = edge_cnt;
      prev_pressed = pressed;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit lvl;
    bit ren_r;
    int len;
    model_reset();

    // Clean press, no repeat, then release.
    begin_scenario();
    for (int c = 1; c <= 240; c++) apply_stimulus(c <= 200, 1'b0, 1'b1);
    want = {18};
    check_pulses("clean", 1000);

    // Bounce: high 10, low 3, then held; final rise lands before edge 14.
    begin_scenario();
    for (int c = 1; c <= 140; c++) apply_stimulus((c <= 10) || (c >= 14 && c <= 100), 1'b0, 1'b1);
    want = {31};
    check_pulses("bounce", 1000);

    // Auto-repeat over the first 150 held cycles.
    begin_scenario();
    for (int c = 1; c <= 190; c++) apply_stimulus(c <= 150, 1'b1, 1'b1);
    want = {18, 82, 98, 114, 130, 146};
    check_pulses("repeat", 150);

    // repeat_en low for edges 91..100 restarts the long delay.
    begin_scenario();
    for (int c = 1; c <= 170; c++) apply_stimulus(1'b1, !(c >= 91 && c <= 100), 1'b1);
    want = {18, 82, 164};
    check_pulses("repeat_gap", 170);

    // Release while still waiting for the first repeat.
    begin_scenario();
    for (int c = 1; c <= 120; c++) apply_stimulus(c <= 40, 1'b1, 1'b1);
    want = {18};
    check_pulses("release", 1000);
    check_output("release_fall_edge", fall_edge, 58);

    // Reset after edge 85 while repeating, released after edge 90; held press re-detected.
    begin_scenario();
    for (int c = 1; c <= 130; c++) apply_stimulus(1'b1, 1'b1, !(c >= 86 && c <= 90));
    want = {18, 82, 18};
    check_pulses("reset_hold", 1000);

    // Random glitches, long holds, repeat_en toggles and occasional resets.
    begin_scenario();
    ren_r = 1'b1;
    for (int seg = 0; seg < 140; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) len = int'($urandom_range(60, 140));
      else len = int'($urandom_range(1, 24));
      if ($urandom_range(0, 3) == 0) ren_r = ~ren_r;
      if ($urandom_range(0, 29) == 0) begin
        for (int k = 0; k < 2; k++) apply_stimulus(lvl, ren_r, 1'b0);
      end
      for (int k = 0; k < len; k++) apply_stimulus(lvl, ren_r, 1'b1);
    end

    repeat (3) @(posedge clock);
    #2;
    check_output("scoreboard_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
